pong_frame_state_regs: RTL and testbench
========================================

# pong_frame_state_regs

Frame-synchronous game-state register bank between the CPU GPIO/bus side and the VGA renderer. Software writes screen mode, menu highlight, speed, ball and N paddle positions into shadow registers, then requests a commit. The shadow set transfers atomically to the renderer-facing registers at the next vertical-blank pulse, so a frame never shows a half-updated scene. It generalises the fixed two-paddle packed-GPIO hookup to a parametrised, addressed, clamped and tear-free interface.

## Interface
- POS_WIDTH, 11, coordinate width in bits
- N_PADDLES, 2, number of paddle channels (1..8)
- H_MAX, 1024, visible width; ball x clamped to H_MAX-1
- V_MAX, 768, visible height; ball y clamped to V_MAX-1
- PADDLE_LEN, 96, paddle height; paddle pos clamped to V_MAX-PADDLE_LEN
- AUTO_COMMIT, 0, 1 = commit at every vblank regardless of request
- ADDR_W, derived = $clog2(N_PADDLES+3), not overridden

- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe, one word per cycle
- wr_addr  in  ADDR_W  register address
- wr_data  in  32  write data
- vblank_start  in  1  one-cycle pulse at start of vertical blank
- screen_mode  out  2  active screen mode
- icon_highlighter  out  2  active menu highlight
- speed_selector  out  2  active game speed
- ball_xpos  out  POS_WIDTH  active ball x
- ball_ypos  out  POS_WIDTH  active ball y
- paddle_pos  out  N_PADDLES*POS_WIDTH  active paddle k at bits [k*POS_WIDTH +: POS_WIDTH]
- commit_pending  out  1  commit requested, not yet applied
- commit_done  out  1  one-cycle pulse in the cycle after an applied commit
- frame_cnt  out  16  vblank counter, wraps 0xFFFF -> 0

## Operation
- Register map (writes only; no read-back):
  - addr 0: control; wr_data[31:30] screen_mode, [29:28] icon_highlighter, [27:26] speed_selector.
  - addr 1: ball; wr_data[POS_WIDTH-1:0] x, wr_data[16 +: POS_WIDTH] y.
  - addr 2..N_PADDLES+1: paddle k = addr-2, wr_data[POS_WIDTH-1:0].
  - addr N_PADDLES+2: commit request; data ignored.
  - Higher addresses: write ignored, no state change.
- Clamping at shadow write: x > H_MAX-1 -> H_MAX-1; y > V_MAX-1 -> V_MAX-1; paddle > V_MAX-PADDLE_LEN -> V_MAX-PADDLE_LEN. Unsigned compare, POS_WIDTH bits.
- Commit control, two states:
  - IDLE: commit write -> PENDING.
  - PENDING: vblank_start -> copy all shadow fields to active, assert commit_done, -> IDLE. Further commit writes stay in PENDING (merged, not counted).
- AUTO_COMMIT=1: copy on every vblank_start; commit writes are accepted but commit_pending stays 0; commit_done pulses every vblank.
- frame_cnt increments on every vblank_start, independent of commits.

## Timing
- Reset: all shadow and active fields 0, commit_pending 0, commit_done 0, frame_cnt 0, state IDLE. Reset mid-PENDING drops the request.
- Shadow write visible internally at the next clk edge; outputs never change from a data write alone.
- commit_pending rises the cycle after the commit write.
- vblank_start in cycle T with pending: active outputs and commit_done valid at T+1; commit_pending low at T+1; commit_done low at T+2.
- Commit write and vblank_start in the same cycle: not applied at this vblank; pending at T+1, applied at the next vblank.
- Data write and applying vblank_start in the same cycle: active takes the pre-write shadow value; the new value waits for the next commit.
- vblank_start without pending (AUTO_COMMIT=0): active unchanged, commit_done stays 0, frame_cnt still increments.
- Back-to-back writes every cycle are supported; there is no backpressure.

## Test plan
- Reset, then vblank_start -> all outputs 0 and frame_cnt=1, commit_done never asserted.
- Write ball x=100, y=200, paddle0=300, control 0x4C000000, commit, then vblank -> at T+1 ball 100/200, paddle0 300, screen_mode=1, icon=0, speed=3, commit_done 1 cycle; before vblank outputs still 0.
- Write x=2047, y=2000, paddle1=1000 (defaults) -> after commit: x=1023, y=767, paddle1=672.
- Commit write coincident with vblank_start -> no update at that vblank; update at the next, commit_pending high in between.
- Write paddle0=50 coincident with the applying vblank (shadow previously 10) -> active paddle0=10; after the next commit+vblank -> 50.
- AUTO_COMMIT=1, N_PADDLES=4: write paddle3=123, no commit, then vblank -> paddle_pos[43:33]=123, commit_pending 0. Write to addr 7 -> ignored. 65536 vblanks -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/pong_frame_state_regs_if.sv
// Write bus from the CPU/GPIO side into the frame state register bank.
// One word per cycle, no backpressure.
interface pong_frame_state_regs_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pong_frame_state_regs.sv
// Shadow/active game-state registers for the VGA renderer.
// Shadow set is copied to the active set atomically on vblank.
module pong_frame_state_regs #(
    parameter int POS_WIDTH   = 11,
    parameter int N_PADDLES   = 2,
    parameter int H_MAX       = 1024,
    parameter int V_MAX       = 768,
    parameter int PADDLE_LEN  = 96,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    pong_frame_state_regs_if.slave         bus,
    input  logic                           vblank_start,
    output logic [1:0]                     screen_mode,
    output logic [1:0]                     icon_highlighter,
    output logic [1:0]                     speed_selector,
    output logic [POS_WIDTH-1:0]           ball_xpos,
    output logic [POS_WIDTH-1:0]           ball_ypos,
    output logic [N_PADDLES*POS_WIDTH-1:0] paddle_pos,
    output logic                           commit_pending,
    output logic                           commit_done,
    output logic [15:0]                    frame_cnt
);
    localparam int ADDR_W = $clog2(N_PADDLES + 3);
    localparam int PW     = N_PADDLES * POS_WIDTH;

    localparam logic [ADDR_W-1:0] A_CTRL   = '0;
    localparam logic [ADDR_W-1:0] A_BALL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(N_PADDLES + 2);

    localparam logic [POS_WIDTH-1:0] X_LIM = POS_WIDTH'(H_MAX - 1);
    localparam logic [POS_WIDTH-1:0] Y_LIM = POS_WIDTH'(V_MAX - 1);
    localparam logic [POS_WIDTH-1:0] P_LIM = POS_WIDTH'(V_MAX - PADDLE_LEN);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    function automatic logic [POS_WIDTH-1:0] clamp(
        input logic [POS_WIDTH-1:0] v,
        input logic [POS_WIDTH-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    state_t state, state_nxt;
    logic   apply;
    logic   commit_wr;
    logic   unused_data;

    logic [1:0]           sh_mode, sh_icon, sh_speed;
    logic [POS_WIDTH-1:0] sh_x, sh_y;
    logic [PW-1:0]        sh_pad;

    assign commit_wr   = bus.wr_en && (bus.wr_addr == A_COMMIT);
    assign unused_data = ^bus.wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_mode  <= '0;
            sh_icon  <= '0;
            sh_speed <= '0;
            sh_x     <= '0;
            sh_y     <= '0;
            sh_pad   <= '0;
        end else if (bus.wr_en) begin
            if (bus.wr_addr == A_CTRL) begin
                sh_mode  <= bus.wr_data[31:30];
                sh_icon  <= bus.wr_data[29:28];
                sh_speed <= bus.wr_data[27:26];
            end
            if (bus.wr_addr == A_BALL) begin
                sh_x <= clamp(bus.wr_data[POS_WIDTH-1:0], X_LIM);
                sh_y <= clamp(bus.wr_data[16 +: POS_WIDTH], Y_LIM);
            end
            for (int k = 0; k < N_PADDLES; k++) begin
                if (bus.wr_addr == ADDR_W'(k + 2)) begin
                    sh_pad[k*POS_WIDTH +: POS_WIDTH] <=
                        clamp(bus.wr_data[POS_WIDTH-1:0], P_LIM);
                end
            end
        end
    end

    // Copy uses the pre-edge shadow, so a same-cycle write waits a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_mode      <= '0;
            icon_highlighter <= '0;
            speed_selector   <= '0;
            ball_xpos        <= '0;
            ball_ypos        <= '0;
            paddle_pos       <= '0;
        end else if (apply) begin
            screen_mode      <= sh_mode;
            icon_highlighter <= sh_icon;
            speed_selector   <= sh_speed;
            ball_xpos        <= sh_x;
            ball_ypos        <= sh_y;
            paddle_pos       <= sh_pad;
        end
    end

    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        if (AUTO_COMMIT != 0) begin
            apply     = vblank_start;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (commit_wr) state_nxt = PENDING;
                end
                PENDING: begin
                    if (vblank_start) begin
                        apply     = 1'b1;
                        state_nxt = commit_wr ? PENDING : IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            commit_done <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            commit_done <= apply;
            if (vblank_start) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign commit_pending = (state == PENDING);
endmodule

// File: tb/tb_pong_frame_state_regs.sv
// Bench for pong_frame_state_regs: default config against a
// reference model, plus an auto-commit 4-paddle instance.
module tb_pong_frame_state_regs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic vb0, vb1;

    pong_frame_state_regs_if #(.ADDR_W(3)) bus0 ();
    pong_frame_state_regs_if #(.ADDR_W(3)) bus1 ();

    logic [1:0]  mode0, icon0, speed0;
    logic [10:0] x0, y0;
    logic [21:0] pad0;
    logic        pend0, done0;
    logic [15:0] frame0;

    logic [1:0]  mode1, icon1, speed1;
    logic [10:0] x1, y1;
    logic [43:0] pad1;
    logic        pend1, done1;
    logic [15:0] frame1;

    pong_frame_state_regs dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .vblank_start(vb0),
        .screen_mode(mode0), .icon_highlighter(icon0),
        .speed_selector(speed0),
        .ball_xpos(x0), .ball_ypos(y0), .paddle_pos(pad0),
        .commit_pending(pend0), .commit_done(done0),
        .frame_cnt(frame0)
    );

    pong_frame_state_regs #(.N_PADDLES(4), .AUTO_COMMIT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .vblank_start(vb1),
        .screen_mode(mode1), .icon_highlighter(icon1),
        .speed_selector(speed1),
        .ball_xpos(x1), .ball_ypos(y1), .paddle_pos(pad1),
        .commit_pending(pend1), .commit_done(done1),
        .frame_cnt(frame1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model for dut0 (2 paddles, explicit commit)
    int sh_mode, sh_icon, sh_speed, sh_x, sh_y;
    int sh_pad[2];
    int ac_mode, ac_icon, ac_speed, ac_x, ac_y;
    int ac_pad[2];
    int m_pend, m_done, m_frame;

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        sh_mode = 0; sh_icon = 0; sh_speed = 0; sh_x = 0; sh_y = 0;
        ac_mode = 0; ac_icon = 0; ac_speed = 0; ac_x = 0; ac_y = 0;
        for (int k = 0; k < 2; k++) begin
            sh_pad[k] = 0;
            ac_pad[k] = 0;
        end
        m_pend = 0; m_done = 0; m_frame = 0;
    endtask

    task automatic check_all0();
        chk("mode", mode0, ac_mode);
        chk("icon", icon0, ac_icon);
        chk("speed", speed0, ac_speed);
        chk("ball_x", x0, ac_x);
        chk("ball_y", y0, ac_y);
        chk("pad0", pad0[10:0], ac_pad[0]);
        chk("pad1", pad0[21:11], ac_pad[1]);
        chk("pending", pend0, m_pend);
        chk("done", done0, m_done);
        chk("frame", frame0, m_frame);
    endtask

    task automatic step0(input bit we, input int addr,
                         input logic [31:0] data, input bit vb);
        bit applied;
        bus0.wr_en   = we;
        bus0.wr_addr = 3'(addr);
        bus0.wr_data = data;
        vb0          = vb;
        @(posedge clk);
        applied = vb && (m_pend != 0);
        if (applied) begin
            ac_mode = sh_mode; ac_icon = sh_icon; ac_speed = sh_speed;
            ac_x = sh_x; ac_y = sh_y;
            ac_pad[0] = sh_pad[0]; ac_pad[1] = sh_pad[1];
        end
        m_done = applied ? 1 : 0;
        if (vb) m_frame = (m_frame + 1) % 65536;
        m_pend = ((m_pend != 0 && !applied) || (we && addr == 4)) ? 1 : 0;
        if (we) begin
            if (addr == 0) begin
                sh_mode  = int'(data[31:30]);
                sh_icon  = int'(data[29:28]);
                sh_speed = int'(data[27:26]);
            end else if (addr == 1) begin
                sh_x = lim(int'(data[10:0]), 1023);
                sh_y = lim(int'(data[26:16]), 767);
            end else if (addr == 2 || addr == 3) begin
                sh_pad[addr-2] = lim(int'(data[10:0]), 672);
            end
        end
        @(negedge clk);
        check_all0();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all0();
    endtask

    task automatic step1(input bit we, input int addr,
                         input logic [31:0] data, input bit vb);
        bus1.wr_en   = we;
        bus1.wr_addr = 3'(addr);
        bus1.wr_data = data;
        vb1          = vb;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        vb0 = 1'b0; vb1 = 1'b0;
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        step0(0, 0, 0, 1);
        chk("frame_after_vb", frame0, 1);
        chk("no_done_idle", done0, 0);

        step0(1, 1, (32'd200 << 16) | 32'd100, 0);
        step0(1, 2, 32'd300, 0);
        step0(1, 0, 32'h4C00_0000, 0);
        step0(1, 4, 32'h0, 0);
        chk("x_before_vb", x0, 0);
        chk("pend_rise", pend0, 1);
        step0(0, 0, 0, 1);
        chk("x_100", x0, 100);
        chk("y_200", y0, 200);
        chk("pad0_300", pad0[10:0], 300);
        chk("mode_1", mode0, 1);
        chk("speed_3", speed0, 3);
        chk("done_pulse", done0, 1);
        step0(0, 0, 0, 0);
        chk("done_drop", done0, 0);

        step0(1, 1, (32'd2000 << 16) | 32'd2047, 0);
        step0(1, 3, 32'd1000, 0);
        step0(1, 4, 32'h0, 0);
        step0(0, 0, 0, 1);
        chk("x_clamp", x0, 1023);
        chk("y_clamp", y0, 767);
        chk("pad1_clamp", pad0[21:11], 672);

        step0(1, 1, 32'd5, 0);
        step0(1, 4, 32'h0, 1);
        chk("coincide_no_apply", x0, 1023);
        chk("coincide_pend", pend0, 1);
        step0(0, 0, 0, 0);
        step0(0, 0, 0, 1);
        chk("coincide_apply", x0, 5);

        step0(1, 2, 32'd10, 0);
        step0(1, 4, 32'h0, 0);
        step0(1, 2, 32'd50, 1);
        chk("pre_write_val", pad0[10:0], 10);
        step0(1, 4, 32'h0, 0);
        step0(0, 0, 0, 1);
        chk("post_write_val", pad0[10:0], 50);

        step0(1, 1, 32'd77, 0);
        step0(1, 4, 32'h0, 0);
        do_reset();
        chk("reset_drops_pend", pend0, 0);
        step0(0, 0, 0, 1);
        chk("reset_no_apply", x0, 0);

        for (int i = 0; i < 3000; i++) begin
            step0($urandom_range(9) < 7, $urandom_range(7),
                  $urandom, $urandom_range(7) == 0);
        end

        bus0.wr_en = 1'b0;
        vb0 = 1'b0;

        step1(1, 5, 32'd123, 0);
        chk("a_write_only", pad1, 0);
        step1(0, 0, 0, 1);
        chk("a_pad3", pad1[43:33], 123);
        chk("a_done", done1, 1);
        chk("a_pend", pend1, 0);
        chk("a_frame1", frame1, 1);
        step1(1, 6, 32'h0, 0);
        chk("a_commit_pend", pend1, 0);
        chk("a_done_low", done1, 0);
        step1(1, 7, 32'hFFFF_FFFF, 0);
        step1(0, 0, 0, 1);
        chk("a_addr7_pad", pad1, 44'd123 << 33);
        chk("a_addr7_ball", {x1, y1}, 0);
        chk("a_addr7_ctrl", {mode1, icon1, speed1}, 0);
        chk("a_frame2", frame1, 2);
        repeat (65533) step1(0, 0, 0, 1);
        chk("a_frame_max", frame1, 16'hFFFF);
        step1(0, 0, 0, 1);
        chk("a_frame_wrap", frame1, 0);
        chk("a_done_wrap", done1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
